vadd_seq_ctrl: RTL and testbench

Issue/collect controller for the serial 16-lane vector adder. It accepts a pair of 256-bit operand vectors from upstream over a valid/ready handshake and drives the adder's level-sensitive `start`. It waits for the adder's `done` pulse, captures `SumV`/`Overflw`, and returns the adder to idle. The result is then presented downstream over a valid/ready handshake. It is the initiator side of the adder's start/done protocol and adds a timeout so a hung unit cannot stall the pipeline.

---
 rtl/vadd_seq_ctrl.sv | 116 +++++++++++
 tb/tb_vadd_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_seq_ctrl.sv
// vadd_seq_ctrl: issue/collect controller for the serial 16-lane vector adder.
// Accepts one operand pair, holds the adder's level start high until done
// or timeout, drains the adder back to idle, then offers the captured result.
module vadd_seq_ctrl #(
    parameter int WIDTH     = 256,
    parameter int TIMEOUT   = 15,
    parameter int DRAIN_CYC = 1
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_err,
    output logic             unit_start,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic [WIDTH-1:0] unit_sum,
    input  logic             unit_ovf,
    input  logic             unit_done,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // The timeout fires on the edge where the incremented wait count hits
    // TIMEOUT, i.e. TIMEOUT edges after the accept edge.
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);
    localparam logic [2:0] DRAIN_LAST  = 3'(DRAIN_CYC - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [2:0] drain_cnt;

    // Single registered FSM: every output is a flop updated here.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_ovf    <= 1'b0;
            out_err    <= 1'b0;
            unit_start <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
            busy       <= 1'b0;
            op_count   <= 16'd0;
            wait_cnt   <= 8'd0;
            drain_cnt  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        unit_a     <= in_a;
                        unit_b     <= in_b;
                        wait_cnt   <= 8'd0;
                        unit_start <= 1'b1;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (unit_done) begin
                        out_sum    <= unit_sum;
                        out_ovf    <= unit_ovf;
                        out_err    <= 1'b0;
                        unit_start <= 1'b0;
                        drain_cnt  <= 3'd0;
                        op_count   <= op_count + 16'd1;
                        state      <= DRAIN;
                    end else if ((wait_cnt + 8'd1) == TIMEOUT_VAL) begin
                        out_sum    <= '0;
                        out_ovf    <= 1'b0;
                        out_err    <= 1'b1;
                        unit_start <= 1'b0;
                        drain_cnt  <= 3'd0;
                        op_count   <= op_count + 16'd1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
// tb_vadd_seq_ctrl: directed bench for the vector adder issue/collect controller.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_vadd_seq_ctrl;

    localparam int W = 256;

    logic          clk1 = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic          out_ovf;
    logic          out_err;
    logic          unit_start;
    logic [W-1:0]  unit_a;
    logic [W-1:0]  unit_b;
    logic [W-1:0]  unit_sum = '0;
    logic          unit_ovf = 1'b0;
    logic          unit_done = 1'b0;
    logic          busy;
    logic [15:0]   op_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] garbage = {8{32'hdeadbeef}};

    vadd_seq_ctrl #(.WIDTH(W), .TIMEOUT(15), .DRAIN_CYC(1)) dut (
        .clk1(clk1), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_ovf(out_ovf), .out_err(out_err),
        .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_sum(unit_sum), .unit_ovf(unit_ovf), .unit_done(unit_done),
        .busy(busy), .op_count(op_count)
    );

    // Free-running 100 MHz clock.
    always #5 clk1 = ~clk1;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Present a pair for exactly one edge; returns 1ns after the accept edge.
    task automatic accept_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        tick();
        in_valid = 1'b0;
        in_a = garbage;
        in_b = ~garbage;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            unit_done = 1'($urandom_range(0, 1));
            unit_ovf  = 1'($urandom_range(0, 1));
            in_a      = {8{$urandom}};
            in_b      = {8{$urandom}};
            unit_sum  = {8{$urandom}};
            tick();
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_sum !== '0) begin errors++; $display("[TB] FAIL reset_out_sum: got %h expected 0", out_sum); end
        checks++; if (out_ovf !== 1'b0 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf_err: got ovf=%b err=%b expected 0/0", out_ovf, out_err); end
        checks++; if (unit_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_unit_start: got %b expected 0", unit_start); end
        checks++; if (unit_a !== '0 || unit_b !== '0) begin errors++; $display("[TB] FAIL reset_unit_ab: got a=%h b=%h expected 0", unit_a, unit_b); end
        checks++; if (busy !== 1'b0 || op_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_busy_count: got busy=%b cnt=%0d expected 0/0", busy, op_count); end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        unit_done = 1'b0;
        unit_ovf = 1'b0;
        unit_sum = '0;
        tick();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_release: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    endtask

    task automatic test_basic_add();
        logic [W-1:0] a = {16{16'h533a}};
        logic [W-1:0] s = {16{16'ha674}};
        accept_pair(a, a);
        checks++; if (unit_start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_accept: got start=%b in_ready=%b busy=%b expected 1/0/1", unit_start, in_ready, busy); end
        checks++; if (unit_a !== a || unit_b !== a) begin errors++; $display("[TB] FAIL basic_unit_ab: got a=%h b=%h expected %h", unit_a, unit_b, a); end
        repeat (4) tick();
        checks++; if (unit_start !== 1'b1) begin errors++; $display("[TB] FAIL basic_start_held: got %b expected 1", unit_start); end
        unit_sum = s;
        unit_ovf = 1'b1;
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        unit_sum = garbage;
        unit_ovf = 1'b0;
        checks++; if (unit_start !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got start=%b out_valid=%b expected 0/0", unit_start, out_valid); end
        checks++; if (op_count !== 16'd1) begin errors++; $display("[TB] FAIL basic_op_count: got %0d expected 1", op_count); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid: got %b expected 1 at E0+6", out_valid); end
        checks++; if (out_sum !== s) begin errors++; $display("[TB] FAIL basic_out_sum: got %h expected %h", out_sum, s); end
        checks++; if (out_ovf !== 1'b1 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf_err: got ovf=%b err=%b expected 1/0", out_ovf, out_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_handshake: got out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a2 = {16{16'h1111}};
        logic [W-1:0] b2 = {16{16'h2222}};
        logic [W-1:0] s2 = {16{16'h3333}};
        logic [W-1:0] a3 = {16{16'h0f0f}};
        logic [W-1:0] b3 = {16{16'h00f0}};
        logic [W-1:0] s3 = {16{16'h0fff}};
        accept_pair(a2, b2);
        tick();
        unit_sum = s2;
        unit_ovf = 1'b0;
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        unit_sum = garbage;
        unit_ovf = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_sum !== s2) begin errors++; $display("[TB] FAIL bp_result: got valid=%b sum=%h expected 1/%h", out_valid, out_sum, s2); end
        in_valid = 1'b1;
        in_a = a3;
        in_b = b3;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== s2 || out_ovf !== 1'b0 || in_ready !== 1'b0 || unit_a !== a2) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid=%b ovf=%b in_ready=%b sum=%h unit_a=%h expected 1/0/0/%h/%h",
                         i, out_valid, out_ovf, in_ready, out_sum, unit_a, s2, a2);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy); end
        tick();
        in_valid = 1'b0;
        checks++; if (unit_a !== a3 || unit_b !== b3 || unit_start !== 1'b1) begin errors++; $display("[TB] FAIL bp_new_accept: got start=%b a=%h b=%h expected 1/%h/%h", unit_start, unit_a, unit_b, a3, b3); end
        unit_sum = s3;
        unit_ovf = 1'b0;
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        unit_sum = garbage;
        tick();
        checks++; if (out_valid !== 1'b1 || out_sum !== s3 || op_count !== 16'd3) begin errors++; $display("[TB] FAIL bp_second_op: got valid=%b cnt=%0d sum=%h expected 1/3/%h", out_valid, op_count, out_sum, s3); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        accept_pair({16{16'h0101}}, {16{16'h0202}});
        repeat (14) tick();
        checks++; if (unit_start !== 1'b1 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL to_before: got start=%b err=%b expected 1/0 at E0+14", unit_start, out_err); end
        tick();
        checks++; if (unit_start !== 1'b0 || out_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_fire: got start=%b err=%b valid=%b expected 0/1/0 at E0+15", unit_start, out_err, out_valid); end
        checks++; if (out_sum !== '0 || out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL to_zeroed: got sum=%h ovf=%b expected 0/0", out_sum, out_ovf); end
        checks++; if (op_count !== 16'd4) begin errors++; $display("[TB] FAIL to_op_count: got %0d expected 4", op_count); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin errors++; $display("[TB] FAIL to_offer: got valid=%b err=%b expected 1/1", out_valid, out_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_boundary();
        logic [W-1:0] s4 = {16{16'h7fff}};
        unit_done = 1'b1;
        unit_sum = s4;
        tick();
        unit_done = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || unit_start !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_done: got busy=%b in_ready=%b start=%b valid=%b expected 0/1/0/0", busy, in_ready, unit_start, out_valid); end
        checks++; if (op_count !== 16'd4 || out_err !== 1'b1) begin errors++; $display("[TB] FAIL idle_done_count: got cnt=%0d err=%b expected 4/1", op_count, out_err); end
        unit_sum = garbage;
        accept_pair({16{16'h3fff}}, {16{16'h4000}});
        repeat (14) tick();
        unit_sum = s4;
        unit_ovf = 1'b1;
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        unit_sum = garbage;
        unit_ovf = 1'b0;
        checks++; if (unit_start !== 1'b0 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL done_at_to: got start=%b err=%b expected 0/0", unit_start, out_err); end
        checks++; if (out_sum !== s4 || out_ovf !== 1'b1 || op_count !== 16'd5) begin errors++; $display("[TB] FAIL done_at_to_capture: got ovf=%b cnt=%0d sum=%h expected 1/5/%h", out_ovf, op_count, out_sum, s4); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL done_at_to_offer: got valid=%b err=%b expected 1/0", out_valid, out_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a = {16{16'h0011}};
        logic [W-1:0] s = {16{16'h0022}};
        accept_pair(a, a);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (unit_start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_run_state: got start=%b busy=%b in_ready=%b expected 0/0/1", unit_start, busy, in_ready); end
        checks++; if (op_count !== 16'd0 || out_valid !== 1'b0 || out_sum !== '0 || unit_a !== '0) begin errors++; $display("[TB] FAIL rst_run_values: got cnt=%0d valid=%b sum=%h expected 0/0/0", op_count, out_valid, out_sum); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_no_valid cycle %0d: got %b expected 0", i, out_valid); end
        end
        accept_pair(a, a);
        tick();
        unit_sum = s;
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        unit_sum = garbage;
        tick();
        checks++; if (out_valid !== 1'b1 || out_sum !== s || out_err !== 1'b0 || op_count !== 16'd1) begin errors++; $display("[TB] FAIL rst_run_recover: got valid=%b err=%b cnt=%0d sum=%h expected 1/0/1/%h", out_valid, out_err, op_count, out_sum, s); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_run_final: got in_ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    // Scenario sequence and summary.
    initial begin
        #1;
        test_reset();
        test_basic_add();
        test_backpressure();
        test_timeout();
        test_boundary();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
